ascon_hash_core: RTL and testbench

- Responder end of the hash-request interface that the HMAC controller drives.
- Accepts a message as a stream of 64-bit blocks, performs Ascon-Hash (v1.2, rate 64, 256-bit digest) using an iterative one-round-per-cycle p12 permutation, and returns the digest with a ready flag.
- Instantiated once per HMAC top.
- Serves both the inner and outer hash passes, one message at a time.

---
 rtl/ascon_hash_core.sv | 187 ++++++++++++++++++
 tb/tb_ascon_hash_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_hash_core.sv
// Ascon-Hash (v1.2, rate 64, 256-bit digest) responder core.
// One p12 round per clock; blocks absorbed into x0, padding applied as an extra full block.
module ascon_hash_core #(
  parameter int HASH_BITS = 256,
  parameter int ROUNDS    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          msg_in,
  input  logic                 msg_start,
  input  logic                 msg_last,
  output logic                 msg_ready,
  output logic [HASH_BITS-1:0] hash_out,
  output logic                 hash_ready
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PERM_MSG = 3'd1;
  localparam logic [2:0] S_WAIT_BLK = 3'd2;
  localparam logic [2:0] S_PERM_PAD = 3'd3;
  localparam logic [2:0] S_PERM_SQZ = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [63:0] IV0 = 64'hee9398aadb67f03d;
  localparam logic [63:0] IV1 = 64'h8bb21831c60f1002;
  localparam logic [63:0] IV2 = 64'hb48a92db98d5da62;
  localparam logic [63:0] IV3 = 64'h43189921b8f8e3e8;
  localparam logic [63:0] IV4 = 64'h348fa5c9d525e140;
  localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;
  localparam logic [3:0]  LAST_RND = 4'(ROUNDS - 1);

  logic [2:0]           state_q, state_d;
  logic [63:0]          x0_q, x1_q, x2_q, x3_q, x4_q;
  logic [63:0]          x0_d, x1_d, x2_d, x3_d, x4_d;
  logic [3:0]           rnd_q, rnd_d;
  logic [1:0]           sqz_q, sqz_d;
  logic                 last_q, last_d;
  logic [HASH_BITS-1:0] hash_q, hash_d;
  logic                 hrdy_q, hrdy_d;
  logic                 accept;
  logic [7:0]           rc;
  logic [63:0]          a0, a1, a2, a3, a4;
  logic [63:0]          s0, s1, s2, s3, s4;
  logic [63:0]          b0, b1, b2, b3, b4;
  logic [63:0]          r0, r1, r2, r3, r4;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign rc        = 8'hF0 - (8'h0F * {4'h0, rnd_q});
  assign msg_ready = (state_q == S_IDLE) || (state_q == S_WAIT_BLK) || (state_q == S_DONE);
  assign accept    = msg_start && msg_ready;
  assign hash_out  = hash_q;
  assign hash_ready = hrdy_q;

  // One round: constant addition, bitsliced S-box, linear diffusion.
  always_comb begin
    a0 = x0_q ^ x4_q;
    a1 = x1_q;
    a2 = x2_q ^ {56'h0, rc} ^ x1_q;
    a3 = x3_q;
    a4 = x4_q ^ x3_q;
    s0 = a0 ^ (~a1 & a2);
    s1 = a1 ^ (~a2 & a3);
    s2 = a2 ^ (~a3 & a4);
    s3 = a3 ^ (~a4 & a0);
    s4 = a4 ^ (~a0 & a1);
    b0 = s0 ^ s4;
    b1 = s1 ^ s0;
    b2 = ~s2;
    b3 = s3 ^ s2;
    b4 = s4;
    r0 = b0 ^ ror(b0, 19) ^ ror(b0, 28);
    r1 = b1 ^ ror(b1, 61) ^ ror(b1, 39);
    r2 = b2 ^ ror(b2, 1)  ^ ror(b2, 6);
    r3 = b3 ^ ror(b3, 10) ^ ror(b3, 17);
    r4 = b4 ^ ror(b4, 7)  ^ ror(b4, 41);
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    x4_d    = x4_q;
    rnd_d   = rnd_q;
    sqz_d   = sqz_q;
    last_d  = last_q;
    hash_d  = hash_q;
    hrdy_d  = hrdy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          x0_d    = IV0 ^ msg_in;
          x1_d    = IV1;
          x2_d    = IV2;
          x3_d    = IV3;
          x4_d    = IV4;
          hash_d  = '0;
          hrdy_d  = 1'b0;
          sqz_d   = '0;
          rnd_d   = '0;
          last_d  = msg_last;
          state_d = S_PERM_MSG;
        end
      end
      S_WAIT_BLK: begin
        if (accept) begin
          x0_d    = x0_q ^ msg_in;
          last_d  = msg_last;
          state_d = S_PERM_MSG;
        end
      end
      S_PERM_MSG, S_PERM_PAD, S_PERM_SQZ: begin
        x0_d  = r0;
        x1_d  = r1;
        x2_d  = r2;
        x3_d  = r3;
        x4_d  = r4;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          rnd_d = '0;
          case (state_q)
            S_PERM_MSG: begin
              // The pad block is a full 0x80.. block folded into the final round edge.
              if (last_q) begin
                x0_d    = r0 ^ PAD;
                state_d = S_PERM_PAD;
              end else begin
                state_d = S_WAIT_BLK;
              end
            end
            S_PERM_PAD: begin
              hash_d[255:192] = r0;
              sqz_d           = '0;
              state_d         = S_PERM_SQZ;
            end
            default: begin
              sqz_d = sqz_q + 2'd1;
              case (sqz_q)
                2'd0:    hash_d[191:128] = r0;
                2'd1:    hash_d[127:64]  = r0;
                default: begin
                  hash_d[63:0] = r0;
                  hrdy_d       = 1'b1;
                  state_d      = S_DONE;
                end
              endcase
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      x4_q    <= '0;
      rnd_q   <= '0;
      sqz_q   <= '0;
      last_q  <= 1'b0;
      hash_q  <= '0;
      hrdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      x4_q    <= x4_d;
      rnd_q   <= rnd_d;
      sqz_q   <= sqz_d;
      last_q  <= last_d;
      hash_q  <= hash_d;
      hrdy_q  <= hrdy_d;
    end
  end

endmodule

// File: tb/tb_ascon_hash_core.sv
// Bench for ascon_hash_core: table of messages checked against a table-lookup S-box Ascon model,
// plus hand sequences for reset abort, ignored strobes and round-constant ordering.
module tb_ascon_hash_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  msg_in;
  logic         msg_start;
  logic         msg_last;
  logic         msg_ready;
  logic [255:0] hash_out;
  logic         hash_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ascon_hash_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg_in     (msg_in),
    .msg_start  (msg_start),
    .msg_last   (msg_last),
    .msg_ready  (msg_ready),
    .hash_out   (hash_out),
    .hash_ready (hash_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [63:0] IV [5] = '{
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140};
  localparam logic [7:0] RC [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  typedef struct {
    logic [63:0]  m0;
    logic [63:0]  m1;
    int           nblk;
    int           gap;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] model_p12(input logic [319:0] s);
    logic [63:0] x [5];
    logic [4:0]  col;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    for (int r = 0; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ RC[r];
      for (int b = 0; b < 64; b++) begin
        col = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = col;
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [255:0] model_hash(input logic [63:0] m0, input logic [63:0] m1,
                                              input int nblk);
    logic [319:0] s;
    logic [255:0] h;
    s = {IV[0] ^ m0, IV[1], IV[2], IV[3], IV[4]};
    s = model_p12(s);
    if (nblk == 2) begin
      s[319:256] = s[319:256] ^ m1;
      s = model_p12(s);
    end
    s[319:256] = s[319:256] ^ 64'h8000_0000_0000_0000;
    s = model_p12(s);
    h[255:192] = s[319:256];
    for (int i = 1; i < 4; i++) begin
      s = model_p12(s);
      h[255 - 64*i -: 64] = s[319:256];
    end
    return h;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive_noise();
    if (!msg_ready) begin
      msg_start = 1'b1;
      msg_in    = {$urandom, $urandom};
      msg_last  = 1'($urandom_range(0, 1));
    end else begin
      msg_start = 1'b0;
      msg_last  = 1'b0;
    end
  endtask

  task automatic run_msg(input string nm, input vec_t v, input bit noise, input bit probe);
    int t0, n, rc_bad, el;
    bit busy_ok, wait_ok;
    n = 0;
    while (!msg_ready && n < 200) begin @(negedge clk); n++; end
    msg_in = v.m0; msg_last = (v.nblk == 1); msg_start = 1'b1;
    @(negedge clk);
    t0 = cyc; msg_start = 1'b0; msg_last = 1'b0;
    chk({nm, "_hrdy_drop"}, hash_ready, 0);
    busy_ok = 1'b1; wait_ok = 1'b1; rc_bad = 0;
    if (v.nblk == 2) begin
      n = 0;
      while (cyc - t0 < 12 && n < 200) begin
        if (msg_ready) busy_ok = 1'b0;
        if (noise) drive_noise();
        @(negedge clk); n++;
      end
      msg_start = 1'b0; msg_last = 1'b0;
      chk({nm, "_ready_at12"}, msg_ready, 1);
      for (int i = 1; i < v.gap; i++) begin
        @(negedge clk);
        if (!msg_ready) wait_ok = 1'b0;
      end
      chk({nm, "_wait_ready"}, wait_ok, 1);
      msg_in = v.m1; msg_last = 1'b1; msg_start = 1'b1;
      @(negedge clk);
      msg_start = 1'b0; msg_last = 1'b0;
    end
    n = 0;
    while (!hash_ready && n < 200) begin
      if (msg_ready) busy_ok = 1'b0;
      el = cyc - t0;
      if (probe && el < 12 && (dut.rnd_q != 4'(el) || dut.rc != RC[el])) rc_bad++;
      if (probe && el == 12 && dut.rnd_q != 4'd0) rc_bad++;
      if (noise) drive_noise();
      @(negedge clk); n++;
    end
    msg_start = 1'b0; msg_last = 1'b0;
    chk({nm, "_latency"}, cyc - t0, (v.nblk == 2) ? 72 + v.gap : 60);
    chk({nm, "_digest"}, hash_out, v.exp);
    chk({nm, "_busy_low"}, busy_ok, 1);
    chk({nm, "_ready_done"}, msg_ready, 1);
    if (probe) begin
      chk({nm, "_rc_order"}, rc_bad, 0);
      chk({nm, "_rnd_wrap"}, dut.rnd_q, 0);
    end
  endtask

  initial begin
    vecs[0] = '{64'h0001020304050607, 64'h0, 1, 0, '0};
    vecs[1] = '{64'h0001020304050607, 64'h08090a0b0c0d0e0f, 2, 5, '0};
    vecs[2] = '{64'hffffffffffffffff, 64'h0, 1, 0, '0};
    vecs[3] = '{64'h0, 64'h0, 1, 0, '0};
    vecs[4] = '{64'h8000000000000000, 64'hdeadbeefcafef00d, 2, 1, '0};
    for (int i = 0; i < 5; i++) vecs[i].exp = model_hash(vecs[i].m0, vecs[i].m1, vecs[i].nblk);

    rst_n = 1'b0; msg_in = '0; msg_start = 1'b0; msg_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", msg_ready, 1);
    chk("rst_hash_ready", hash_ready, 0);
    chk("rst_hash_out", hash_out, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_rnd", dut.rnd_q, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_msg($sformatf("vec%0d", i), vecs[i], 1'b0, 1'(i == 0));

    run_msg("noise1", vecs[0], 1'b1, 1'b0);
    run_msg("noise2", vecs[1], 1'b1, 1'b0);

    // Abort a hash partway through the first permutation.
    msg_in = vecs[1].m0; msg_last = 1'b0; msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_msg_ready", msg_ready, 1);
    chk("abort_hash_ready", hash_ready, 0);
    chk("abort_hash_out", hash_out, 0);
    chk("abort_state", dut.state_q, 0);
    chk("abort_x0", dut.x0_q, 0);
    chk("abort_rnd", dut.rnd_q, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_msg("post_rst", vecs[0], 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
